// File: rtl/stim_sig_engine.sv
// rtl/stim_sig_engine.sv - stored-vector stimulus player with MISR response signature
// Plays num_vec vectors for HOLD cycles each and compacts delayed DUT responses into a MISR.
module stim_sig_engine #(
  parameter int IN_W  = 256,
  parameter int OUT_W = 242,
  parameter int DEPTH = 32,
  parameter int HOLD  = 1,
  parameter int LAT   = 1,
  parameter logic [OUT_W-1:0] POLY = {{(OUT_W-1){1'b0}}, 1'b1},
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [IN_W-1:0]  load_data,
  input  logic [AW:0]      num_vec,
  input  logic             start,
  input  logic [OUT_W-1:0] exp_sig,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] dut_out,
  output logic [AW-1:0]    vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);

  typedef enum logic [1:0] {IDLE, APPLY, DRAIN, DONE} state_t;

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int TW = (LAT > 0) ? LAT : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [AW:0]   DEPTH_V    = (AW+1)'(DEPTH);

  logic [IN_W-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [AW:0]      num_q, num_d;
  logic [OUT_W-1:0] sig_q, sig_d;
  logic             pass_q, pass_d;
  logic [TW-1:0]    tag_q, tag_d;

  logic             busy_w, tag_now, cap;
  logic [AW:0]      num_sat;
  logic [AW-1:0]    idx_nxt;
  logic [IN_W-1:0]  first_vec, next_vec;

  assign busy_w    = (state_q == APPLY) || (state_q == DRAIN);
  assign num_sat   = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
  assign idx_nxt   = idx_q + 1'b1;
  // A write in the start cycle must reach the first driven vector
  assign first_vec = (load_en && (load_addr == '0)) ? load_data : mem[0];
  assign next_vec  = mem[idx_nxt];
  assign tag_now   = (state_q == APPLY) && (hold_q == HOLD_LAST);
  assign cap       = (LAT == 0) ? tag_now : tag_q[TW-1];

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    drain_d = drain_q;
    num_d   = num_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    tag_d   = (tag_q << 1) | TW'(tag_now);

    if (cap) begin
      sig_d = {sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? POLY : '0) ^ dut_out;
    end

    case (state_q)
      IDLE: begin
        stim_d = '0;
        if (start) begin
          num_d   = num_sat;
          sig_d   = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          hold_d  = '0;
          drain_d = '0;
          if (num_sat != '0) begin
            state_d = APPLY;
            stim_d  = first_vec;
          end else if (LAT == 0) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      APPLY: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if ({1'b0, idx_q} == num_q - 1'b1) begin
            stim_d  = '0;
            drain_d = '0;
            if (LAT == 0) state_d = DONE;
            else          state_d = DRAIN;
          end else begin
            idx_d  = idx_nxt;
            stim_d = next_vec;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Compare against the signature including the final update landing this edge
    if (state_d == DONE) pass_d = (sig_d == exp_sig);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stim_q  <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      drain_q <= '0;
      num_q   <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
      num_q   <= num_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
      tag_q   <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && !busy_w) mem[load_addr] <= load_data;
  end

  assign stim      = stim_q;
  assign vec_idx   = idx_q;
  assign busy      = busy_w;
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_stim_sig_engine.sv
// tb/tb_stim_sig_engine.sv - randomized self-checking bench for stim_sig_engine
// Instance a: HOLD=1 LAT=0, dut_out=stim. Instance b: HOLD=3 LAT=2, dut_out=stim delayed 2.
module tb_stim_sig_engine;

  logic       clk = 1'b0;
  logic       rst, load_en, start;
  logic [1:0] load_addr;
  logic [7:0] load_data, exp_sig;
  logic [2:0] num_vec;

  logic [7:0] stim_a, sig_a, stim_b, sig_b, dly1_b, dly2_b;
  logic [1:0] idx_a, idx_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;

  logic [7:0] model_mem [4];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dly1_b <= stim_b;
    dly2_b <= dly1_b;
  end

  stim_sig_engine #(.IN_W(8), .OUT_W(8), .DEPTH(4), .HOLD(1), .LAT(0), .POLY(8'h1D)) u_dut_a (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .num_vec(num_vec), .start(start), .exp_sig(exp_sig), .stim(stim_a), .dut_out(stim_a),
    .vec_idx(idx_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a)
  );

  stim_sig_engine #(.IN_W(8), .OUT_W(8), .DEPTH(4), .HOLD(3), .LAT(2), .POLY(8'h1D)) u_dut_b (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .num_vec(num_vec), .start(start), .exp_sig(exp_sig), .stim(stim_b), .dut_out(dly2_b),
    .vec_idx(idx_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] misr_of(input int n);
    logic [7:0] s;
    s = 8'h00;
    for (int v = 0; v < n; v++) s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ model_mem[v];
    return s;
  endfunction

  task automatic chk_rst_vals(input string nm);
    chk({nm, ".a.stim"}, stim_a, 0); chk({nm, ".a.idx"}, idx_a, 0);
    chk({nm, ".a.busy"}, busy_a, 0); chk({nm, ".a.done"}, done_a, 0);
    chk({nm, ".a.pass"}, pass_a, 0); chk({nm, ".a.sig"}, sig_a, 0);
    chk({nm, ".b.stim"}, stim_b, 0); chk({nm, ".b.idx"}, idx_b, 0);
    chk({nm, ".b.busy"}, busy_b, 0); chk({nm, ".b.done"}, done_b, 0);
    chk({nm, ".b.pass"}, pass_b, 0); chk({nm, ".b.sig"}, sig_b, 0);
  endtask

  // Expected behaviour of one instance k cycles after the start cycle
  task automatic chk_inst(input string nm, input int h, input int l, input int k, input int n,
                          input logic [7:0] msig, input logic [7:0] xsig,
                          input logic [7:0] st, input logic [1:0] ix, input logic bz,
                          input logic dn, input logic ps, input logic [7:0] sg);
    int dcyc;
    dcyc = n * h + l + 1;
    if (k <= n * h) begin
      chk({nm, ".stim"}, st, model_mem[(k-1)/h]);
      chk({nm, ".idx"}, ix, (k-1)/h);
      chk({nm, ".busy"}, bz, 1);
    end else begin
      chk({nm, ".stim"}, st, 0);
      chk({nm, ".busy"}, bz, (k < dcyc) ? 1 : 0);
    end
    chk({nm, ".done"}, dn, (k == dcyc) ? 1 : 0);
    chk({nm, ".pass"}, ps, ((k >= dcyc) && (msig == xsig)) ? 1 : 0);
    if (k >= dcyc) chk({nm, ".sig"}, sg, msig);
  endtask

  task automatic load(input int addr, input logic [7:0] data);
    load_en = 1'b1; load_addr = 2'(addr); load_data = data;
    model_mem[addr] = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic do_run(input int n_req, input int exp_sel, input bit disturb, input bit wr0);
    int n, last;
    logic [7:0] msig, xsig;
    n = (n_req > 4) ? 4 : n_req;
    if (wr0) begin
      load_en = 1'b1; load_addr = 2'd0; load_data = 8'($urandom);
      model_mem[0] = load_data;
    end
    msig = misr_of(n);
    if (exp_sel >= 0)                  xsig = 8'(exp_sel);
    else if ($urandom_range(0, 1) == 1) xsig = msig;
    else                               xsig = 8'($urandom);
    exp_sig = xsig; num_vec = 3'(n_req); start = 1'b1;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    last = 3 * n + 2 + 1 + 2;
    for (int k = 1; k <= last; k++) begin
      chk_inst("run.a", 1, 0, k, n, msig, xsig, stim_a, idx_a, busy_a, done_a, pass_a, sig_a);
      chk_inst("run.b", 3, 2, k, n, msig, xsig, stim_b, idx_b, busy_b, done_b, pass_b, sig_b);
      if (disturb && k == 1) begin
        start = 1'b1; load_en = 1'b1;
        load_addr = 2'($urandom_range(0, 3)); load_data = 8'($urandom);
      end else begin
        start = 1'b0; load_en = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    num_vec = 3'd1; exp_sig = '0;
    repeat (3) @(negedge clk);
    chk_rst_vals("reset");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post_reset.a.busy", busy_a, 0);
    chk("post_reset.b.busy", busy_b, 0);

    load(0, 8'h01); load(1, 8'h02); load(2, 8'($urandom)); load(3, 8'($urandom));
    do_run(2, 8'h00, 0, 0);
    load(0, 8'h80); load(1, 8'h01);
    do_run(2, 8'h1C, 0, 0);
    do_run(2, 8'h1D, 0, 0);
    do_run(0, 8'h00, 0, 0);
    do_run(7, -1, 0, 0);
    do_run(3, -1, 1, 0);
    do_run(2, -1, 0, 1);

    num_vec = 3'd3; exp_sig = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_rst_vals("midrun_reset");
    rst = 1'b0;
    do_run(3, -1, 0, 0);

    for (int r = 0; r < 12; r++) begin
      int nv;
      repeat ($urandom_range(0, 3)) load($urandom_range(0, 3), 8'($urandom));
      nv = $urandom_range(0, 7);
      do_run(nv, -1, (nv > 0) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stim_sig_engine.md
STIM_SIG_ENGINE -- requirements
Module: stim_sig_engine

Interface
REQ-001 Parameter IN_W, default 256, SHALL set the stimulus vector width in bits.
REQ-002 Parameter OUT_W, default 242, SHALL set the DUT response width and the signature width in bits.
REQ-003 Parameter DEPTH, default 32, SHALL set the number of stored stimulus vectors; AW = clog2(DEPTH).
REQ-004 Parameter HOLD, default 1, minimum 1, SHALL set the number of cycles each vector is driven.
REQ-005 Parameter LAT, default 1, minimum 0, SHALL set the DUT response latency in cycles.
REQ-006 Parameter POLY, OUT_W bits, default 1 (LSB set), SHALL set the MISR feedback polynomial.
REQ-007 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 load_en  in  1  write strobe for the vector memory.
REQ-010 load_addr  in  AW  vector memory write address.
REQ-011 load_data  in  IN_W  vector memory write data.
REQ-012 num_vec  in  AW+1  vectors to play (0..DEPTH), sampled on start.
REQ-013 start  in  1  one-cycle run request.
REQ-014 exp_sig  in  OUT_W  expected signature, sampled when entering DONE.
REQ-015 stim  out  IN_W  registered stimulus to the DUT.
REQ-016 dut_out  in  OUT_W  DUT response.
REQ-017 vec_idx  out  AW  index of the vector currently driven.
REQ-018 busy  out  1  high from the cycle after an accepted start until done.
REQ-019 done  out  1  one-cycle completion pulse.
REQ-020 pass  out  1  signature == exp_sig, valid from done until the next start.
REQ-021 signature  out  OUT_W  MISR contents.

Function
REQ-022 FSM states SHALL be IDLE, APPLY, DRAIN and DONE.
REQ-023 IDLE: stim SHALL be all-zero; start SHALL latch num_vec, clear the signature and pass, and move to APPLY (or to DRAIN when num_vec == 0).
REQ-024 APPLY: stim SHALL equal mem[vec_idx] for exactly HOLD cycles per vector, with vec_idx running 0..num_vec-1 and no gap between vectors.
REQ-025 Latency: for start high in cycle t, stim SHALL equal mem[0] in cycle t+1.
REQ-026 A capture tag SHALL be raised in the last hold cycle of each vector and delayed by LAT cycles; when the delayed tag is high, the MISR SHALL update.
REQ-027 MISR update: sig <= {sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1] ? POLY : 0) ^ dut_out, computed modulo 2^OUT_W.
REQ-028 After the final hold cycle of the last vector, stim SHALL return to zero and the FSM SHALL enter DRAIN for LAT cycles; with LAT = 0 it SHALL go directly to DONE.
REQ-029 DONE SHALL last one cycle: done = 1, pass = (signature == exp_sig), busy = 0; the next state SHALL be IDLE.
REQ-030 Exactly num_vec MISR updates SHALL occur per run; num_vec > DEPTH SHALL be saturated to DEPTH.
REQ-031 start SHALL be ignored while busy; load_en SHALL be ignored while busy; a memory write and a start in the same IDLE cycle SHALL both take effect, and the write SHALL be visible to the run.
REQ-032 signature and pass SHALL hold their values after DONE until the next accepted start.

Reset
REQ-033 rst SHALL force IDLE, stim = 0, vec_idx = 0, busy = 0, done = 0, pass = 0, signature = 0, and clear all capture tags, including mid-run.
REQ-034 Vector memory contents SHALL NOT be affected by rst.
REQ-035 start asserted together with rst SHALL be ignored.

Verification (IN_W = OUT_W = 8, POLY = 8'h1D, DEPTH = 4, dut_out tied to stim unless stated otherwise)
REQ-036 HOLD = 1, LAT = 0, mem = {01,02}, num_vec = 2, exp_sig = 00 -> stim 01, 02, 00; signature 00; done at t+3; pass = 1.
REQ-037 HOLD = 1, LAT = 0, mem = {80,01}, exp_sig = 1C -> signature 1C; pass = 1; exp_sig = 1D -> pass = 0.
REQ-038 HOLD = 3, LAT = 2, dut_out = stim delayed 2 cycles, mem = {80,01} -> each vector driven 3 cycles; 2 MISR updates; signature 1C; done at t+9.
REQ-039 num_vec = 0, exp_sig = 00 -> no MISR update; done at t+1; pass = 1.
REQ-040 rst pulsed in the second APPLY cycle -> next cycle all outputs at reset values; a following start replays the same memory contents with an identical signature.
REQ-041 start and load_en pulsed while busy -> run unaffected, memory unchanged, and exactly one done pulse.
